spih_device_responder: RTL



---
 rtl/spih_device_responder_if.sv | 19 +
 rtl/spih_device_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/spih_device_responder_if.sv
// rtl/spih_device_responder_if.sv - SPI pin bundle between host fixture and device responder

interface spih_device_responder_if;
  logic spi_sck_i;
  logic spi_csb_i;
  logic spi_mosi_i;
  logic spi_miso_o;
  logic spi_miso_en_o;

  modport master (
    output spi_sck_i, spi_csb_i, spi_mosi_i,
    input  spi_miso_o, spi_miso_en_o
  );

  modport slave (
    input  spi_sck_i, spi_csb_i, spi_mosi_i,
    output spi_miso_o, spi_miso_en_o
  );
endinterface

// File: rtl/spih_device_responder.sv
// rtl/spih_device_responder.sv - oversampled mode-0 SPI target backed by a byte memory

module spih_device_responder #(
  parameter int MemBytes   = 256,
  parameter int AddrBytes  = 1,
  parameter int SyncStages = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  spih_device_responder_if.slave        spi,
  output logic                          busy_o,
  output logic                          cmd_err_o,
  output logic [7:0]                    wr_count_o
);
  localparam int AW   = (MemBytes > 2) ? $clog2(MemBytes) : 1;
  localparam int AdrW = 8 * AddrBytes;
  localparam int AcW  = (AddrBytes > 1) ? $clog2(AddrBytes) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_READ, ST_WRITE, ST_STATUS, ST_IGNORE
  } state_e;

  state_e                r_state, w_state_next;
  logic [SyncStages-1:0] r_sck_sync, r_csb_sync, r_mosi_sync;
  logic                  r_sck_d, r_csb_d;
  logic                  w_sck_s, w_csb_s, w_mosi_s;
  logic                  w_rise, w_fall, w_cs_assert, w_byte_done, w_last_abyte;
  logic [7:0]            r_shift, w_byte, r_tx, r_status, r_wr_count;
  logic [2:0]            r_bitcnt;
  logic [AdrW-1:0]       r_addr_sh, w_addr_next;
  logic [AcW-1:0]        r_abyte_cnt;
  logic [AW-1:0]         r_ptr, w_ptr_inc, w_load_ptr;
  logic                  r_is_write, r_miso, r_cmd_err, w_cmd_err_next;
  logic [7:0]            r_mem [MemBytes];

  assign w_sck_s  = r_sck_sync[SyncStages-1];
  assign w_csb_s  = r_csb_sync[SyncStages-1];
  assign w_mosi_s = r_mosi_sync[SyncStages-1];

  // A deasserted CS masks any sck edge seen in the same cycle.
  assign w_rise      = w_sck_s & ~r_sck_d & ~w_csb_s;
  assign w_fall      = ~w_sck_s & r_sck_d & ~w_csb_s;
  // Only a falling CS edge starts a command, so after a reset mid-transaction
  // the device stays idle until the host releases and re-asserts CS.
  assign w_cs_assert = ~w_csb_s & r_csb_d;

  assign w_byte       = {r_shift[6:0], w_mosi_s};
  assign w_byte_done  = w_rise && (r_bitcnt == 3'd7);
  assign w_addr_next  = (r_addr_sh << 8) | AdrW'(w_byte);
  assign w_load_ptr   = AW'(w_addr_next);
  assign w_ptr_inc    = r_ptr + AW'(1);
  assign w_last_abyte = (r_abyte_cnt == AcW'(AddrBytes - 1));

  assign busy_o            = (r_state != ST_IDLE);
  assign cmd_err_o         = r_cmd_err;
  assign wr_count_o        = r_wr_count;
  assign spi.spi_miso_en_o = (r_state == ST_READ) || (r_state == ST_STATUS);
  assign spi.spi_miso_o    = r_miso;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_cmd_err_next = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_cs_assert) w_state_next = ST_CMD;
      ST_CMD: begin
        if (w_byte_done) begin
          unique case (w_byte)
            8'h03, 8'h02: w_state_next = ST_ADDR;
            8'h05:        w_state_next = ST_STATUS;
            default: begin
              w_state_next   = ST_IGNORE;
              w_cmd_err_next = 1'b1;
            end
          endcase
        end
      end
      ST_ADDR: begin
        if (w_byte_done && w_last_abyte) w_state_next = r_is_write ? ST_WRITE : ST_READ;
      end
      default: ;
    endcase
    if ((r_state != ST_IDLE) && w_csb_s) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sck_sync  <= '0;
      r_csb_sync  <= '0;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_csb_d     <= 1'b0;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_addr_sh   <= '0;
      r_abyte_cnt <= '0;
      r_ptr       <= '0;
      r_tx        <= '0;
      r_status    <= '0;
      r_is_write  <= 1'b0;
      r_miso      <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_wr_count  <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SyncStages-2:0], spi.spi_sck_i};
      r_csb_sync  <= {r_csb_sync[SyncStages-2:0], spi.spi_csb_i};
      r_mosi_sync <= {r_mosi_sync[SyncStages-2:0], spi.spi_mosi_i};
      r_sck_d     <= w_sck_s;
      r_csb_d     <= w_csb_s;
      r_cmd_err   <= w_cmd_err_next;

      if ((r_state == ST_IDLE) || w_csb_s) begin
        r_bitcnt    <= '0;
        r_shift     <= '0;
        r_abyte_cnt <= '0;
      end else if (w_rise && (r_state != ST_IGNORE)) begin
        r_shift  <= w_byte;
        r_bitcnt <= r_bitcnt + 3'd1;
      end

      if (w_byte_done) begin
        unique case (r_state)
          ST_CMD: begin
            r_is_write  <= (w_byte == 8'h02);
            r_abyte_cnt <= '0;
            if (w_byte == 8'h05) begin
              r_tx     <= r_wr_count;
              r_status <= r_wr_count;
            end
          end
          ST_ADDR: begin
            r_addr_sh   <= w_addr_next;
            r_abyte_cnt <= r_abyte_cnt + AcW'(1);
            if (w_last_abyte) begin
              r_ptr <= w_load_ptr;
              if (!r_is_write) r_tx <= r_mem[w_load_ptr];
            end
          end
          ST_READ: begin
            r_ptr <= w_ptr_inc;
            r_tx  <= r_mem[w_ptr_inc];
          end
          ST_STATUS: r_tx <= r_status;
          ST_WRITE: begin
            r_ptr      <= w_ptr_inc;
            r_wr_count <= r_wr_count + 8'd1;
          end
          default: ;
        endcase
      end

      if (w_fall && ((r_state == ST_READ) || (r_state == ST_STATUS))) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
      if ((w_state_next != ST_READ) && (w_state_next != ST_STATUS)) r_miso <= 1'b0;
    end
  end

  // Memory is deliberately left out of reset so data survives a bring-up reset.
  always_ff @(posedge clk_i) begin
    if ((r_state == ST_WRITE) && w_byte_done && !w_csb_s) r_mem[r_ptr] <= w_byte;
  end
endmodule
